// File: rtl/frogger_pkg.sv
// Shared defaults, scanner state encoding and index helpers for the frog/car collision logic.
package frogger_pkg;

    localparam int DEF_COORD_W     = 10;
    localparam int DEF_BLOCKSIZE   = 32;
    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_FROG_SIZE   = 32;
    localparam int DEF_LANE_BASE_Y = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [15:0] lane;
        logic [15:0] car;
    } lane_car_t;

    // Flattened car index is lane*cars_per_lane + car.
    function automatic lane_car_t idx_to_lane_car(input int idx, input int cars_per_lane);
        lane_car_t r;
        r.lane = 16'(idx / cars_per_lane);
        r.car  = 16'(idx % cars_per_lane);
        return r;
    endfunction

endpackage

// File: rtl/span_overlap.sv
// Horizontal overlap between the frog square and one car span, with the car wrapping at the screen edge.
module span_overlap #(
    parameter int COORD_W   = 10,
    parameter int FROG_SIZE = 32,
    parameter int SCREEN_W  = 640
) (
    input  logic [COORD_W-1:0] frog_x,
    input  logic [COORD_W-1:0] car_x,
    input  logic [COORD_W-1:0] car_len,
    output logic               x_hit
);

    localparam int W = COORD_W + 1;

    logic [W-1:0] fx_lo;
    logic [W-1:0] fx_hi;
    logic [W-1:0] car_lo;
    logic [W-1:0] car_end;
    logic [W-1:0] wrap_end;

    assign fx_lo    = {1'b0, frog_x};
    assign fx_hi    = fx_lo + W'(FROG_SIZE);
    assign car_lo   = {1'b0, car_x};
    assign car_end  = car_lo + {1'b0, car_len};
    assign wrap_end = car_end - W'(SCREEN_W);

    always_comb begin
        x_hit = 1'b0;
        if (car_len != '0) begin
            if (car_end <= W'(SCREEN_W)) begin
                x_hit = (fx_lo < car_end) && (fx_hi > car_lo);
            end else begin
                // Wrapped car: tail segment [x, SCREEN_W) plus head segment [0, end-SCREEN_W).
                x_hit = ((fx_lo < W'(SCREEN_W)) && (fx_hi > car_lo)) || (fx_lo < wrap_end);
            end
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// Time-multiplexed frog-vs-car collision checker: snapshots positions on start, tests one car per cycle.
module collision_scanner
    import frogger_pkg::*;
#(
    parameter int NUM_LANES     = 6,
    parameter int CARS_PER_LANE = 3,
    parameter int COORD_W       = DEF_COORD_W,
    parameter int BLOCKSIZE     = DEF_BLOCKSIZE,
    parameter int LANE_BASE_Y   = DEF_LANE_BASE_Y,
    parameter int FROG_SIZE     = DEF_FROG_SIZE,
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int EARLY_EXIT    = 1
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       start,
    input  logic [COORD_W-1:0]                         frog_x,
    input  logic [COORD_W-1:0]                         frog_y,
    input  logic [NUM_LANES*CARS_PER_LANE*COORD_W-1:0] car_x,
    input  logic [NUM_LANES*COORD_W-1:0]               lane_len,
    input  logic [NUM_LANES-1:0]                       lane_en,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       collision,
    output logic [$clog2(NUM_LANES)-1:0]               hit_lane,
    output logic [$clog2(CARS_PER_LANE)-1:0]           hit_car
);

    localparam int N     = NUM_LANES * CARS_PER_LANE;
    localparam int IDX_W = $clog2(N);
    localparam int LW    = $clog2(NUM_LANES);
    localparam int CW    = $clog2(CARS_PER_LANE);
    localparam int YW    = COORD_W + 1;

    scan_state_e       state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              col_q, col_d;
    logic [LW-1:0]     hit_lane_q, hit_lane_d;
    logic [CW-1:0]     hit_car_q, hit_car_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [CW-1:0]     car_q, car_d;
    logic              found_q, found_d;
    logic [LW-1:0]     first_lane_q, first_lane_d;
    logic [CW-1:0]     first_car_q, first_car_d;
    logic [COORD_W-1:0] frog_x_q, frog_x_d;
    logic [COORD_W-1:0] frog_y_q, frog_y_d;
    logic [COORD_W-1:0] car_x_q [N];
    logic [COORD_W-1:0] car_x_d [N];
    logic [COORD_W-1:0] len_q [NUM_LANES];
    logic [COORD_W-1:0] len_d [NUM_LANES];
    logic [NUM_LANES-1:0] en_q, en_d;

    logic [IDX_W-1:0]   cur_idx;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_len;
    logic [YW-1:0]      lane_top;
    logic [YW-1:0]      frog_top;
    logic               y_hit;
    logic               x_hit;
    logic               hit;
    logic               last;
    logic               take_snap;

    assign cur_idx  = IDX_W'(lane_q) * IDX_W'(CARS_PER_LANE) + IDX_W'(car_q);
    assign cur_x    = car_x_q[cur_idx];
    assign cur_len  = len_q[lane_q];
    assign lane_top = YW'(LANE_BASE_Y) + YW'(lane_q) * YW'(BLOCKSIZE);
    assign frog_top = {1'b0, frog_y_q};
    assign y_hit    = (frog_top < lane_top + YW'(BLOCKSIZE)) && (frog_top + YW'(FROG_SIZE) > lane_top);
    assign hit      = en_q[lane_q] && y_hit && x_hit;
    assign last     = (lane_q == LW'(NUM_LANES - 1)) && (car_q == CW'(CARS_PER_LANE - 1));

    span_overlap #(
        .COORD_W   (COORD_W),
        .FROG_SIZE (FROG_SIZE),
        .SCREEN_W  (SCREEN_W)
    ) u_span (
        .frog_x  (frog_x_q),
        .car_x   (cur_x),
        .car_len (cur_len),
        .x_hit   (x_hit)
    );

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        col_d        = col_q;
        hit_lane_d   = hit_lane_q;
        hit_car_d    = hit_car_q;
        lane_d       = lane_q;
        car_d        = car_q;
        found_d      = found_q;
        first_lane_d = first_lane_q;
        first_car_d  = first_car_q;
        frog_x_d     = frog_x_q;
        frog_y_d     = frog_y_q;
        car_x_d      = car_x_q;
        len_d        = len_q;
        en_d         = en_q;
        take_snap    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    take_snap = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (hit && !found_q) begin
                    found_d      = 1'b1;
                    first_lane_d = lane_q;
                    first_car_d  = car_q;
                end
                if (((EARLY_EXIT != 0) && hit) || last) begin
                    state_d = DONE;
                end else if (car_q == CW'(CARS_PER_LANE - 1)) begin
                    car_d  = '0;
                    lane_d = lane_q + 1'b1;
                end else begin
                    car_d = car_q + 1'b1;
                end
            end
            DONE: begin
                done_d     = 1'b1;
                col_d      = found_q;
                hit_lane_d = first_lane_q;
                hit_car_d  = first_car_q;
                // A start here publishes this result and opens the next scan on the same edge.
                if (start) begin
                    take_snap = 1'b1;
                    state_d   = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_snap) begin
            frog_x_d     = frog_x;
            frog_y_d     = frog_y;
            en_d         = lane_en;
            lane_d       = '0;
            car_d        = '0;
            found_d      = 1'b0;
            first_lane_d = '0;
            first_car_d  = '0;
            for (int i = 0; i < N; i++) car_x_d[i] = car_x[i*COORD_W +: COORD_W];
            for (int l = 0; l < NUM_LANES; l++) len_d[l] = lane_len[l*COORD_W +: COORD_W];
        end

        busy_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            col_q        <= 1'b0;
            hit_lane_q   <= '0;
            hit_car_q    <= '0;
            lane_q       <= '0;
            car_q        <= '0;
            found_q      <= 1'b0;
            first_lane_q <= '0;
            first_car_q  <= '0;
            frog_x_q     <= '0;
            frog_y_q     <= '0;
            en_q         <= '0;
            for (int i = 0; i < N; i++) car_x_q[i] <= '0;
            for (int l = 0; l < NUM_LANES; l++) len_q[l] <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            col_q        <= col_d;
            hit_lane_q   <= hit_lane_d;
            hit_car_q    <= hit_car_d;
            lane_q       <= lane_d;
            car_q        <= car_d;
            found_q      <= found_d;
            first_lane_q <= first_lane_d;
            first_car_q  <= first_car_d;
            frog_x_q     <= frog_x_d;
            frog_y_q     <= frog_y_d;
            en_q         <= en_d;
            car_x_q      <= car_x_d;
            len_q        <= len_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = col_q;
    assign hit_lane  = hit_lane_q;
    assign hit_car   = hit_car_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a pixel-level reference model checked every cycle.
module tb_collision_scanner;
    import frogger_pkg::*;

    localparam int NL  = 6;
    localparam int CPL = 3;
    localparam int CW  = 10;
    localparam int N   = NL * CPL;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic start = 1'b0;
    logic [CW-1:0] frog_x = '0;
    logic [CW-1:0] frog_y = '0;
    logic [N*CW-1:0] car_x = '0;
    logic [NL*CW-1:0] lane_len = '0;
    logic [NL-1:0] lane_en = '0;
    logic busy, done, collision;
    logic [2:0] hit_lane;
    logic [1:0] hit_car;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    collision_scanner dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .car_x     (car_x),
        .lane_len  (lane_len),
        .lane_en   (lane_en),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .hit_lane  (hit_lane),
        .hit_car   (hit_car)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk every frog pixel row/column against each car's covered pixels; lowest hit index or -1.
    function automatic int first_hit(input logic [CW-1:0] fx, input logic [CW-1:0] fy,
                                     input logic [N*CW-1:0] cx, input logic [NL*CW-1:0] ll,
                                     input logic [NL-1:0] en);
        for (int i = 0; i < N; i++) begin
            int lane;
            int x;
            int len;
            int top;
            bit yov;
            bit xov;
            lane = i / CPL;
            x    = int'(cx[i*CW +: CW]);
            len  = int'(ll[lane*CW +: CW]);
            top  = 256 + 32 * lane;
            yov  = 1'b0;
            xov  = 1'b0;
            if (en[lane] && len > 0) begin
                for (int r = int'(fy); r < int'(fy) + 32; r++)
                    if (r >= top && r < top + 32) yov = 1'b1;
                for (int p = int'(fx); p < int'(fx) + 32; p++) begin
                    if (p >= x && p < x + len && p < 640) xov = 1'b1;
                    if (x + len > 640 && p < x + len - 640) xov = 1'b1;
                end
                if (yov && xov) return i;
            end
        end
        return -1;
    endfunction

    int   m_cnt = 0;
    logic m_busy = 1'b0, m_done = 1'b0, m_col = 1'b0;
    int   m_lane = 0, m_car = 0;
    logic p_col = 1'b0;
    int   p_lane = 0, p_car = 0;

    // Model: a scan accepted at an edge publishes k+2 edges later on a hit, N+1 otherwise.
    always @(posedge clk or negedge reset_n) begin : model
        int cnt_n;
        int k;
        lane_car_t lc;
        if (!reset_n) begin
            m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0;
            m_col <= 1'b0; m_lane <= 0; m_car <= 0;
        end else begin
            cnt_n = (m_cnt > 0) ? m_cnt - 1 : 0;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                m_col <= p_col; m_lane <= p_lane; m_car <= p_car;
            end
            if (cnt_n == 0 && start) begin
                k  = first_hit(frog_x, frog_y, car_x, lane_len, lane_en);
                lc = idx_to_lane_car((k < 0) ? 0 : k, CPL);
                p_col  <= (k >= 0);
                p_lane <= int'(lc.lane);
                p_car  <= int'(lc.car);
                cnt_n  = (k >= 0) ? k + 2 : N + 1;
            end
            m_cnt  <= cnt_n;
            m_busy <= (cnt_n > 1);
        end
    end

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("collision", 32'(collision), 32'(m_col));
            check("hit_lane", 32'(hit_lane), 32'(m_lane));
            check("hit_car", 32'(hit_car), 32'(m_car));
        end
    end

    task automatic set_car(input int idx, input int x);
        car_x[idx*CW +: CW] = CW'(x);
    endtask

    task automatic fill(input int x, input int len);
        for (int i = 0; i < N; i++) set_car(i, x);
        for (int l = 0; l < NL; l++) lane_len[l*CW +: CW] = CW'(len);
        lane_en = '1;
    endtask

    task automatic cfg_default();
        frog_x = 10'd320; frog_y = 10'd448;
        fill(0, 64);
    endtask

    task automatic cfg_lane1(input int fx);
        frog_x = CW'(fx); frog_y = 10'd288;
        fill(400, 64);
        set_car(4, 90);
    endtask

    task automatic cfg_wrap(input bit en0);
        frog_x = 10'd0; frog_y = 10'd256;
        fill(400, 64);
        set_car(0, 620);
        lane_en[0] = en0;
    endtask

    task automatic run_scan(input string name, input int exp_lat, input int exp_col,
                            input int exp_lane, input int exp_car);
        int s;
        int seen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; s = cyc;
        frog_x = ~frog_x; car_x = ~car_x;
        seen = -1;
        for (int i = 0; i < 60 && seen < 0; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) seen = cyc;
        end
        if (seen < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: no done within 60 cycles", name);
        end else begin
            check({name, "_latency"}, 32'(seen - s), 32'(exp_lat));
            check({name, "_collision"}, 32'(collision), 32'(exp_col));
            check({name, "_lane"}, 32'(hit_lane), 32'(exp_lane));
            check({name, "_car"}, 32'(hit_car), 32'(exp_car));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int ndone;
        int t1;
        int t2;

        // Model pins against hand-derived first-hit indices.
        cfg_default();     check("model_default", 32'(first_hit(frog_x, frog_y, car_x, lane_len, lane_en)), 32'hFFFF_FFFF);
        cfg_lane1(100);    check("model_lane1", 32'(first_hit(frog_x, frog_y, car_x, lane_len, lane_en)), 32'd4);
        cfg_lane1(154);    check("model_edge154", 32'(first_hit(frog_x, frog_y, car_x, lane_len, lane_en)), 32'hFFFF_FFFF);
        cfg_wrap(1'b1);    check("model_wrap", 32'(first_hit(frog_x, frog_y, car_x, lane_len, lane_en)), 32'd0);
        cfg_wrap(1'b0);    check("model_wrap_dis", 32'(first_hit(frog_x, frog_y, car_x, lane_len, lane_en)), 32'hFFFF_FFFF);

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_lane", 32'(hit_lane), 32'd0);
        check("rst_car", 32'(hit_car), 32'd0);
        chk_en = 1'b1;
        @(negedge clk); reset_n = 1'b1;

        cfg_default();     run_scan("full_nohit", 19, 0, 0, 0);
        cfg_lane1(100);    run_scan("lane1_car1", 6, 1, 1, 1);
        cfg_wrap(1'b1);    run_scan("wrap", 2, 1, 0, 0);
        cfg_wrap(1'b0);    run_scan("wrap_disabled", 19, 0, 0, 0);
        cfg_lane1(154);    run_scan("edge154", 19, 0, 0, 0);
        cfg_lane1(153);    run_scan("edge153", 6, 1, 1, 1);

        // start during SCAN is ignored; start held in the DONE cycle chains a second scan.
        cfg_default();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; s = cyc;
        ndone = 0; t1 = -1; t2 = -1;
        for (int m = 0; m <= 45; m++) begin
            if (m > 0) begin
                @(negedge clk);
                #1;
            end
            if (done === 1'b1) begin
                ndone++;
                if (t1 < 0) t1 = cyc - s; else t2 = cyc - s;
            end
            start = (m + 1 == 3) || (m + 1 == 10) || (m + 1 == 19);
        end
        start = 1'b0;
        check("chain_first_done", 32'(t1), 32'd19);
        check("chain_second_done", 32'(t2), 32'd38);
        check("chain_done_count", 32'(ndone), 32'd2);

        // Abort mid-scan by reset while a previous hit result is still displayed.
        cfg_lane1(100);    run_scan("pre_abort", 6, 1, 1, 1);
        cfg_default();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        #1 check("abort_busy_before", 32'(busy), 32'd1);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_collision", 32'(collision), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        cfg_lane1(100);    run_scan("post_abort", 6, 1, 1, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Parametrised, time-multiplexed frog-vs-car overlap checker.
- Replaces the fixed 6-lane x 3-car combinational collision OR-tree in the top level.
- Snapshots frog and car positions on a start pulse (issued once per frame, e.g. at VSYNC), then tests one car per cycle.
- Reports a registered collision flag plus the lane and car index of the first hit; supports horizontal screen wrap of cars.

Parameters:
- NUM_LANES, 6, number of car lanes.
- CARS_PER_LANE, 3, cars per lane.
- COORD_W, 10, coordinate width in bits.
- BLOCKSIZE, 32, lane height in pixels.
- LANE_BASE_Y, 256, top y of lane 0; lane i top = LANE_BASE_Y + i*BLOCKSIZE.
- FROG_SIZE, 32, frog square edge in pixels.
- SCREEN_W, 640, horizontal wrap modulus for car spans.
- EARLY_EXIT, 1, 1 = stop the scan at the first hit; 0 = always scan all cars.

Ports:
- clk  in  1  pixel clock (25.175 MHz domain).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a scan.
- frog_x  in  COORD_W  frog left x.
- frog_y  in  COORD_W  frog top y.
- car_x  in  NUM_LANES*CARS_PER_LANE*COORD_W  car left x, flattened; index = lane*CARS_PER_LANE + car.
- lane_len  in  NUM_LANES*COORD_W  car length per lane.
- lane_en  in  NUM_LANES  per-lane enable mask; disabled lanes never hit.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when results update.
- collision  out  1  result of the last completed scan.
- hit_lane  out  $clog2(NUM_LANES)  lane of the first hit; 0 if no hit.
- hit_car  out  $clog2(CARS_PER_LANE)  car of the first hit; 0 if no hit.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; busy, done, collision, hit_lane, hit_car, index counter and all snapshot registers = 0.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 -> capture frog_x, frog_y, all car_x, lane_len and lane_en into snapshot registers; index=0; go to SCAN. busy goes high the following cycle.
- SCAN: each cycle evaluate the car at the current index against the snapshot.
  - Hit -> record the first hit's lane/car.
  - EARLY_EXIT=1 and hit -> go to DONE.
  - index = N-1, where N = NUM_LANES*CARS_PER_LANE -> go to DONE.
  - Otherwise index++ (lane/car counters; car wraps to 0 and increments lane).
- DONE: done=1 for exactly one cycle; update collision, hit_lane and hit_car; busy=0; next state IDLE.
- Latency, start sampled at edge 0:
  - Full scan: done asserted in cycle N+1 (19 with defaults).
  - Early exit at index k: done asserted in cycle k+2.
- start handling:
  - start in SCAN is ignored and not queued.
  - start in DONE is accepted: results publish and a new snapshot is taken in the same edge; next state SCAN.
- Outputs hold their values between scans; the live inputs may change freely during a scan (no tearing).
- Y overlap for lane L: frog_y < laneTop+BLOCKSIZE and frog_y+FROG_SIZE > laneTop.
  - Compute in COORD_W+1 bits; no overflow truncation.
- X overlap without wrap (x+len <= SCREEN_W): frog_x < x+len and frog_x+FROG_SIZE > x, in COORD_W+1 bits.
- X overlap with wrap (x+len > SCREEN_W): the car covers [x, SCREEN_W) and [0, x+len-SCREEN_W). Hit if the frog overlaps either segment.
- Hit requires lane_en[L]=1 and both X and Y overlap.
- Zero lane length never hits.
- With EARLY_EXIT=0, hit_lane/hit_car report the lowest index that hit.
- reset_n low mid-scan aborts immediately: all outputs return to 0, no done pulse.

Decomposition:
- frogger_pkg holds:
  - COORD_W, BLOCKSIZE, SCREEN_W, FROG_SIZE and LANE_BASE_Y defaults.
  - The scanner state enum (IDLE/SCAN/DONE).
  - An index-to-lane/car helper function.
- Sub-module span_overlap: purely combinational.
  - Inputs: frog_x, car_x, car_len.
  - Output: x_hit, including wrap handling.
  - Instantiated once, since evaluation is serial.

Test Plan:
- Defaults; frog (320,448), cars all at x=0, len 64 -> done at cycle 19; collision=0; hit_lane=0, hit_car=0.
- Frog (100,288); lane1 car1 x=90, len 64; EARLY_EXIT=1 -> hit at index 4; done at cycle 6; collision=1; hit_lane=1, hit_car=1.
- Wrap: frog (0,256); lane0 car0 x=620, len 64 (covers 620..639 and 0..43) -> collision=1, lane 0, car 0. Same case with lane_en[0]=0 -> collision=0.
- Boundary: frog_x=154; car x=90, len 64 (ends at 154, exclusive) -> no hit. Frog_x=153 -> hit.
- start pulsed at cycles 3 and 10 during a scan -> both ignored, a single done pulse. start asserted in the DONE cycle -> new scan begins, second done 19 cycles later.
- reset_n low at cycle 7 of a scan -> busy, collision and done = 0 immediately; no done pulse; the next start scans normally.
